// File: rtl/xgs_regbus_arbiter.sv
// -----------------------------------------------------------------------------
// xgs_regbus_arbiter
//
// Shares the single XGS_athena register-file port between N_MASTERS
// requesters (host BAR, sensor-init sequencer, validation driver, ...).
// Requesters are arbitrated round-robin. One read or write at a time is
// issued downstream. The arbiter then waits for completion under a timeout
// guard and returns data and status to the requester that won.
//
// Handshake:
//   Master side: m_req[i] is a level request. m_rnw/m_addr/m_wdata are held
//   stable while it is high. m_req is sampled only while the arbiter is idle.
//   Completion is a one-cycle m_ack[i] pulse, and m_rdata/m_err are valid in
//   that cycle. The master drops m_req on the edge after m_ack.
//   Register side: reg_read/reg_write is a one-cycle strobe. reg_addr and
//   reg_wdata stay stable until the response. reg_done is a one-cycle
//   completion pulse, and reg_rdata is valid with it. reg_done is ignored
//   unless the arbiter is waiting.
//
// Ports:
//   sys_clk, sys_reset        clock, asynchronous active-high reset
//   m_req/m_rnw               per-master request and direction (1 = read)
//   m_addr/m_wdata            packed per-master address / write data
//   m_ack/m_grant             completion pulse / one-hot current owner
//   m_rdata/m_err             returned data / timeout flag (valid with m_ack)
//   reg_read/reg_write        downstream strobes
//   reg_addr/reg_wdata        downstream address / write data
//   reg_rdata/reg_done        downstream read data / completion pulse
//   busy                      arbiter not idle
//   timeout_cnt               saturating timeout counter
//   dbg_state                 FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
// -----------------------------------------------------------------------------
module xgs_regbus_arbiter #(
   parameter int                N_MASTERS = 4,
   parameter int                ADDR_W    = 11,
   parameter int                DATA_W    = 32,
   parameter int                TIMEOUT   = 1023,
   parameter logic [DATA_W-1:0] ERR_DATA  = DATA_W'(32'hBADC_0FFE)
) (
   input  logic                          sys_clk,
   input  logic                          sys_reset,
   input  logic [N_MASTERS-1:0]          m_req,
   input  logic [N_MASTERS-1:0]          m_rnw,
   input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
   input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
   output logic [N_MASTERS-1:0]          m_ack,
   output logic [N_MASTERS-1:0]          m_grant,
   output logic [DATA_W-1:0]             m_rdata,
   output logic                          m_err,
   output logic                          reg_read,
   output logic                          reg_write,
   output logic [ADDR_W-1:0]             reg_addr,
   output logic [DATA_W-1:0]             reg_wdata,
   input  logic [DATA_W-1:0]             reg_rdata,
   input  logic                          reg_done,
   output logic                          busy,
   output logic [7:0]                    timeout_cnt,
   output logic [1:0]                    dbg_state
);

   localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W:0] NM = (IDX_W + 1)'(N_MASTERS);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [IDX_W-1:0]     last_grant_q, last_grant_d;
   logic [IDX_W-1:0]     win_q, win_d;
   logic [N_MASTERS-1:0] grant_q, grant_d;
   logic                 rnw_q, rnw_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [DATA_W-1:0]    wdata_q, wdata_d;
   logic [TMR_W-1:0]     timer_q, timer_d;
   logic [DATA_W-1:0]    rdata_q, rdata_d;
   logic                 err_q, err_d;
   logic [7:0]           tocnt_q, tocnt_d;

   // Round-robin search: the first requester found, starting one above the
   // last winner and wrapping past N_MASTERS-1 back to 0.
   logic                 arb_found;
   logic [IDX_W-1:0]     arb_idx;
   logic [IDX_W:0]       cand;

   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= N_MASTERS; k++) begin
         cand = {1'b0, last_grant_q} + (IDX_W + 1)'(k);
         if (cand >= NM) begin
            cand = cand - NM;
         end
         if (!arb_found && m_req[cand[IDX_W-1:0]]) begin
            arb_found = 1'b1;
            arb_idx   = cand[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      win_d        = win_q;
      grant_d      = grant_q;
      rnw_d        = rnw_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      timer_d      = timer_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      tocnt_d      = tocnt_q;
      case (state_q)
         S_IDLE: begin
            if (arb_found) begin
               win_d   = arb_idx;
               grant_d = N_MASTERS'(1) << arb_idx;
               rnw_d   = m_rnw[arb_idx];
               addr_d  = m_addr[arb_idx*ADDR_W +: ADDR_W];
               wdata_d = m_wdata[arb_idx*DATA_W +: DATA_W];
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // reg_done takes priority over the timeout in the same cycle.
            if (reg_done) begin
               rdata_d = rnw_q ? reg_rdata : '0;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
               // timer_q counts completed WAIT cycles, so this is WAIT cycle TIMEOUT.
               rdata_d = ERR_DATA;
               err_d   = 1'b1;
               if (tocnt_q != 8'hFF) begin
                  tocnt_d = tocnt_q + 8'd1;
               end
               state_d = S_RESP;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         S_RESP: begin
            last_grant_d = win_q;
            grant_d      = '0;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_reset) begin
      if (sys_reset) begin
         state_q      <= S_IDLE;
         last_grant_q <= IDX_W'(N_MASTERS - 1);
         win_q        <= '0;
         grant_q      <= '0;
         rnw_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         timer_q      <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
         tocnt_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         win_q        <= win_d;
         grant_q      <= grant_d;
         rnw_q        <= rnw_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         timer_q      <= timer_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
         tocnt_q      <= tocnt_d;
      end
   end

   assign m_grant     = grant_q;
   assign m_ack       = (state_q == S_RESP) ? grant_q : '0;
   assign m_rdata     = rdata_q;
   assign m_err       = err_q;
   assign reg_read    = (state_q == S_ISSUE) &&  rnw_q;
   assign reg_write   = (state_q == S_ISSUE) && !rnw_q;
   assign reg_addr    = addr_q;
   assign reg_wdata   = wdata_q;
   assign busy        = (state_q != S_IDLE);
   assign timeout_cnt = tocnt_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_xgs_regbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_xgs_regbus_arbiter
//
// Bench for xgs_regbus_arbiter with 4 masters and TIMEOUT=16. The bench plays
// the masters and the downstream register file. A transaction-level reference
// model tracks the owner, the cycles since the grant, the returned data and the
// timeout count. A compare process checks every DUT output against that model
// on every cycle. Directed scenarios add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_xgs_regbus_arbiter;

   localparam int          N   = 4;
   localparam int          AW  = 11;
   localparam int          DW  = 32;
   localparam int          TO  = 16;
   localparam logic [31:0] ERR = 32'hBADC_0FFE;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic sys_reset;
   always #5 clk = ~clk;

   logic [N-1:0]    m_req, m_rnw, m_ack, m_grant;
   logic [N*AW-1:0] m_addr;
   logic [N*DW-1:0] m_wdata;
   logic [DW-1:0]   m_rdata, reg_wdata, reg_rdata;
   logic            m_err, reg_read, reg_write, reg_done, busy;
   logic [AW-1:0]   reg_addr;
   logic [7:0]      timeout_cnt;
   logic [1:0]      dbg_state;

   xgs_regbus_arbiter #(
      .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .ERR_DATA(ERR)
   ) dut (
      .sys_clk(clk), .sys_reset(sys_reset),
      .m_req(m_req), .m_rnw(m_rnw), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ack(m_ack), .m_grant(m_grant), .m_rdata(m_rdata), .m_err(m_err),
      .reg_read(reg_read), .reg_write(reg_write), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_done(reg_done),
      .busy(busy), .timeout_cnt(timeout_cnt), .dbg_state(dbg_state)
   );

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   logic [DW-1:0] exp_q[$];
   int            order_q[$];

   int            ack_cnt = 0, ack_cyc = 0, ack_idx = -1;
   logic          ack_err;
   int            strobe_cnt = 0, strobe_cyc = 0, raise_cyc = 0;
   logic          strobe_rd;
   logic [AW-1:0] strobe_addr;
   logic [DW-1:0] strobe_wdata;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   int            mdl_owner, mdl_last, mdl_wait, mdl_tocnt;
   bit            mdl_resp;
   logic          mdl_rnw, mdl_err;
   logic [AW-1:0] mdl_addr;
   logic [DW-1:0] mdl_wdata, mdl_rdata;

   function automatic int arb(input logic [N-1:0] req, input int last);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (last + k) % N;
         if (req[c]) return c;
      end
      return -1;
   endfunction

   // mdl_wait: 0 in the strobe cycle, then 1..TO over the waiting cycles.
   always @(posedge clk or posedge sys_reset) begin
      if (sys_reset) begin
         mdl_owner <= -1;
         mdl_last  <= N - 1;
         mdl_wait  <= 0;
         mdl_resp  <= 1'b0;
         mdl_rnw   <= 1'b0;
         mdl_addr  <= '0;
         mdl_wdata <= '0;
         mdl_rdata <= '0;
         mdl_err   <= 1'b0;
         mdl_tocnt <= 0;
      end else if (mdl_owner < 0) begin
         if (m_req != '0) begin
            mdl_owner <= arb(m_req, mdl_last);
            mdl_rnw   <= m_rnw[arb(m_req, mdl_last)];
            mdl_addr  <= m_addr[arb(m_req, mdl_last)*AW +: AW];
            mdl_wdata <= m_wdata[arb(m_req, mdl_last)*DW +: DW];
            mdl_wait  <= 0;
            mdl_resp  <= 1'b0;
         end
      end else if (mdl_resp) begin
         mdl_last  <= mdl_owner;
         mdl_owner <= -1;
         mdl_resp  <= 1'b0;
      end else if (mdl_wait == 0) begin
         mdl_wait <= 1;
      end else if (reg_done) begin
         mdl_rdata <= mdl_rnw ? reg_rdata : '0;
         mdl_err   <= 1'b0;
         mdl_resp  <= 1'b1;
      end else if (mdl_wait == TO) begin
         mdl_rdata <= ERR;
         mdl_err   <= 1'b1;
         mdl_tocnt <= (mdl_tocnt < 255) ? mdl_tocnt + 1 : 255;
         mdl_resp  <= 1'b1;
      end else begin
         mdl_wait <= mdl_wait + 1;
      end
   end

   // ---------------- compare process + event log ----------------
   logic [N-1:0] exp_grant, exp_ack;
   logic         exp_strobe;

   always @(posedge clk) begin
      #1;
      cyc++;
      if (chk_en) begin
         exp_grant  = (mdl_owner >= 0) ? (N'(1) << mdl_owner) : '0;
         exp_ack    = (mdl_owner >= 0 && mdl_resp) ? (N'(1) << mdl_owner) : '0;
         exp_strobe = (mdl_owner >= 0) && (mdl_wait == 0) && !mdl_resp;
         chk("m_grant", m_grant, exp_grant);
         chk("m_ack", m_ack, exp_ack);
         chk("reg_read", reg_read, exp_strobe && mdl_rnw);
         chk("reg_write", reg_write, exp_strobe && !mdl_rnw);
         chk("reg_addr", reg_addr, mdl_addr);
         chk("reg_wdata", reg_wdata, mdl_wdata);
         chk("m_rdata", m_rdata, mdl_rdata);
         chk("m_err", m_err, mdl_err);
         chk("busy", busy, mdl_owner >= 0);
         chk("timeout_cnt", timeout_cnt, mdl_tocnt);

         if (reg_read || reg_write) begin
            strobe_cnt++;
            strobe_cyc   = cyc;
            strobe_rd    = reg_read;
            strobe_addr  = reg_addr;
            strobe_wdata = reg_wdata;
         end
         if (m_ack != '0) begin
            ack_cnt++;
            ack_cyc = cyc;
            ack_err = m_err;
            for (int i = 0; i < N; i++) if (m_ack[i]) ack_idx = i;
            order_q.push_back(ack_idx);
            if (exp_q.size() > 0) chk("sb_rdata", m_rdata, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver state ----------------
   int            pend[N];
   logic          d_rnw[N];
   logic [AW-1:0] d_addr[N];
   logic [DW-1:0] d_wdata[N];
   bit            rand_fields = 1'b0, withdraw_en = 1'b0;
   bit            sl_rand = 1'b0, sl_fixed_en = 1'b0, stray_done = 1'b0;
   int            sl_dly = 1, sl_cnt = 0;
   logic [DW-1:0] sl_fixed = '0;

   // One cycle of master and register-file behaviour, driven at the falling edge.
   task automatic step();
      @(negedge clk);
      reg_done  = 1'b0;
      reg_rdata = $urandom;
      if (stray_done) begin
         reg_done   = 1'b1;
         stray_done = 1'b0;
      end
      if (sl_cnt > 0) begin
         sl_cnt--;
         if (sl_cnt == 0) begin
            reg_done = 1'b1;
            if (sl_fixed_en) reg_rdata = sl_fixed;
         end
      end
      // delay 0 = never answer
      if (reg_read || reg_write) sl_cnt = sl_rand ? $urandom_range(0, 20) : sl_dly;
      for (int i = 0; i < N; i++) begin
         if (m_ack[i]) begin
            m_req[i] = 1'b0;
         end else if (!m_req[i] && pend[i] > 0) begin
            if (rand_fields) begin
               m_rnw[i]            = 1'($urandom_range(0, 1));
               m_addr[i*AW +: AW]  = AW'($urandom);
               m_wdata[i*DW +: DW] = $urandom;
            end else begin
               m_rnw[i]            = d_rnw[i];
               m_addr[i*AW +: AW]  = d_addr[i];
               m_wdata[i*DW +: DW] = d_wdata[i];
            end
            m_req[i]  = 1'b1;
            raise_cyc = cyc;
            pend[i]--;
         end else if (m_req[i] && !m_grant[i] && withdraw_en && $urandom_range(0, 39) == 0) begin
            m_req[i] = 1'b0;
         end
      end
   endtask

   task automatic clear_stim();
      m_req      = '0;
      reg_done   = 1'b0;
      sl_cnt     = 0;
      stray_done = 1'b0;
      for (int i = 0; i < N; i++) pend[i] = 0;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      sys_reset = 1'b1;
      clear_stim();
      repeat (2) @(negedge clk);
      sys_reset = 1'b0;
   endtask

   task automatic wait_acks(input int n, input int budget, input string name);
      int start;
      start = ack_cnt;
      for (int k = 0; k < budget && ack_cnt < start + n; k++) step();
      chk(name, ack_cnt - start, n);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int a0, s0;
      int exp_order[6];
      exp_order = '{0, 1, 2, 3, 0, 1};

      sys_reset = 1'b0;
      m_rnw     = '0;
      m_addr    = '0;
      m_wdata   = '0;
      reg_rdata = '0;
      clear_stim();
      #1 sys_reset = 1'b1;
      #2;
      chk("rst_m_ack", m_ack, 0);
      chk("rst_m_grant", m_grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_strobes", {reg_read, reg_write}, 0);
      chk("rst_m_rdata", m_rdata, 0);
      chk("rst_timeout_cnt", timeout_cnt, 0);
      repeat (2) @(negedge clk);
      sys_reset = 1'b0;
      chk_en    = 1'b1;

      // 1: single read by master 1, register file answers 3 cycles after the strobe
      d_rnw[1] = 1'b1; d_addr[1] = 11'h040; d_wdata[1] = 32'h0;
      sl_dly = 3; sl_fixed_en = 1'b1; sl_fixed = 32'h1234_5678;
      exp_q.push_back(32'h1234_5678);
      pend[1] = 1;
      wait_acks(1, 40, "t1_ack_seen");
      chk("t1_req_to_strobe", strobe_cyc - raise_cyc, 1);
      chk("t1_strobe_read", strobe_rd, 1);
      chk("t1_reg_addr", strobe_addr, 11'h040);
      chk("t1_latency", ack_cyc - strobe_cyc, 4);
      chk("t1_ack_master", ack_idx, 1);
      chk("t1_err", ack_err, 0);
      sl_fixed_en = 1'b0;

      // 2: all four masters keep requesting, answers 1 cycle after the strobe
      reset_dut();
      order_q.delete();
      rand_fields = 1'b1; sl_dly = 1;
      for (int i = 0; i < N; i++) pend[i] = 2;
      wait_acks(8, 120, "t2_acks");
      chk("t2_count", order_q.size(), 8);
      for (int i = 0; i < 6 && i < order_q.size(); i++) chk("t2_order", order_q[i], exp_order[i]);
      for (int i = 1; i < order_q.size(); i++) chk("t2_no_repeat", order_q[i] != order_q[i-1], 1);
      rand_fields = 1'b0;

      // 3: write from master 2 is never answered
      reset_dut();
      d_rnw[2] = 1'b0; d_addr[2] = 11'h7FF; d_wdata[2] = 32'hA5A5_A5A5;
      sl_dly = 0;
      exp_q.push_back(32'hBADC_0FFE);
      pend[2] = 1;
      wait_acks(1, 60, "t3_ack_seen");
      chk("t3_strobe_write", strobe_rd, 0);
      chk("t3_reg_addr", strobe_addr, 11'h7FF);
      chk("t3_reg_wdata", strobe_wdata, 32'hA5A5_A5A5);
      chk("t3_latency", ack_cyc - strobe_cyc, 17);
      chk("t3_err", ack_err, 1);
      chk("t3_timeout_cnt", timeout_cnt, 1);

      // 4: answer lands on the last waiting cycle, so it wins over the timeout
      d_rnw[0] = 1'b1; d_addr[0] = 11'h123; d_wdata[0] = 32'h0;
      sl_dly = 16; sl_fixed_en = 1'b1; sl_fixed = 32'hCAFE_F00D;
      exp_q.push_back(32'hCAFE_F00D);
      pend[0] = 1;
      wait_acks(1, 60, "t4_ack_seen");
      chk("t4_latency", ack_cyc - strobe_cyc, 17);
      chk("t4_err", ack_err, 0);
      chk("t4_timeout_cnt", timeout_cnt, 1);
      sl_fixed_en = 1'b0;

      // 5: reset while master 3 is waiting
      reset_dut();
      d_rnw[3] = 1'b1; d_addr[3] = 11'h155; d_wdata[3] = 32'h5A5A_0001;
      sl_dly = 0;
      pend[3] = 1;
      s0 = strobe_cnt;
      for (int k = 0; k < 20 && strobe_cnt == s0; k++) step();
      repeat (3) step();
      chk("t5_busy_before", busy, 1);
      a0 = ack_cnt;
      #2 sys_reset = 1'b1;
      #1;
      chk("t5_rst_ack", m_ack, 0);
      chk("t5_rst_grant", m_grant, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_addr", reg_addr, 0);
      chk("t5_rst_wdata", reg_wdata, 0);
      chk("t5_rst_strobes", {reg_read, reg_write}, 0);
      chk("t5_rst_rdata_err", {m_rdata, m_err}, 0);
      clear_stim();
      repeat (3) @(negedge clk);
      sys_reset = 1'b0;
      chk("t5_no_ack", ack_cnt - a0, 0);
      order_q.delete();
      d_rnw[0] = 1'b0; d_addr[0] = 11'h011;
      sl_dly = 1;
      pend[0] = 1; pend[3] = 1;
      wait_acks(2, 40, "t5_acks");
      if (order_q.size() >= 2) begin
         chk("t5_first", order_q[0], 0);
         chk("t5_second", order_q[1], 3);
      end else begin
         chk("t5_order_len", order_q.size(), 2);
      end

      // 6: stray done while idle, then 300 back-to-back timeouts
      repeat (3) step();
      a0 = ack_cnt;
      stray_done = 1'b1;
      repeat (3) step();
      chk("t6_stray_busy", busy, 0);
      chk("t6_stray_ack", ack_cnt - a0, 0);
      d_rnw[1] = 1'b0; d_addr[1] = 11'h2AA; d_wdata[1] = 32'h0BAD_CAFE;
      sl_dly = 0;
      pend[1] = 300;
      wait_acks(300, 300 * 20 + 50, "t6_acks");
      chk("t6_saturated", timeout_cnt, 255);

      // random traffic: random fields, random answer delays, occasional withdrawals
      reset_dut();
      rand_fields = 1'b1; sl_rand = 1'b1; withdraw_en = 1'b1;
      for (int i = 0; i < N; i++) pend[i] = $urandom_range(20, 60);
      a0 = ack_cnt;
      repeat (2500) step();
      for (int i = 0; i < N; i++) pend[i] = 0;
      withdraw_en = 1'b0;
      repeat (60) step();
      chk("rand_progress", ack_cnt > a0, 1);
      chk("sb_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
